// File: rtl/pixel_burst_reader.sv
// Fetches one 8-pixel group (16bpp or 24bpp) from the framebuffer over AXI read and streams the pixels out.
// Latency: ARVALID 3 cycles after the request; pixels start the cycle after the final R beat.
// Backpressure: AR is held until ar_ready_i, R stalls outside RDATA, and each pixel is held until pix_ready_i.
// Optional feature macro: PIXEL_READ_RRESP_CHECK_EN. When defined, a non-OKAY RRESP sets a sticky err_o.
module pixel_burst_reader #(
   parameter int BOUNDARY_W = 12,
   parameter int STRIDE_W   = 14
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pixel_mode_24_i,
   input  logic [31:0]         src_addr_i,
   input  logic [STRIDE_W-1:0] pixel_stride_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [15:0]         req_x_i,
   input  logic [15:0]         req_y_i,
   output logic                ar_valid_o,
   input  logic                ar_ready_i,
   output logic [31:0]         ar_addr_o,
   output logic [2:0]          ar_len_o,
   input  logic                r_valid_i,
   output logic                r_ready_o,
   input  logic [31:0]         r_data_i,
   input  logic [1:0]          r_resp_i,
   input  logic                r_last_i,
   output logic                pix_valid_o,
   input  logic                pix_ready_i,
   output logic [23:0]         pix_data_o,
   output logic                pix_last_o,
   output logic                err_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_CALC0, S_CALC1, S_SPLIT, S_AR1, S_AR2, S_RDATA, S_EMIT
   } state_t;

   localparam int ROOM_W     = BOUNDARY_W - 1;
   localparam int PAGE_WORDS = 1 << (BOUNDARY_W - 2);
   localparam int YOFF_W     = 16 + STRIDE_W;

   state_t              r_state;
   logic [15:0]         r_x;
   logic [15:0]         r_y;
   logic [17:0]         r_xoff;
   logic [YOFF_W-1:0]   r_yoff;
   logic [31:0]         r_addr;
   logic [2:0]          r_beats;
   logic                r_two;
   logic [31:0]         r_ar2_addr;
   logic [2:0]          r_ar2_len;
   logic [2:0]          r_beat_cnt;
   logic [2:0]          r_pix_k;
   logic [191:0]        r_buf;
   logic                r_req_ready;
   logic                r_ar_valid;
   logic [31:0]         r_ar_addr;
   logic [2:0]          r_ar_len;
   logic                r_r_ready;
   logic                r_pix_valid;
   logic [23:0]         r_pix_data;
   logic                r_pix_last;
   logic                r_err;

   logic [2:0]          w_beats;
   logic [ROOM_W-1:0]   w_room;
   logic                w_fits;
   logic [2:0]          w_len1;
   logic [2:0]          w_len2;
   logic [31:0]         w_page2;
   logic                w_beat_acc;
   logic                w_pix_hs;
   logic [2:0]          w_next_k;
   logic                w_unused;

   // Selects pixel k out of the assembled group buffer for the active pixel format.
   function automatic logic [23:0] f_pixel(input logic [191:0] b, input logic [2:0] k, input logic m24);
      logic [7:0] base24;
      logic [6:0] base16;
      base24 = {5'd0, k} * 8'd24;
      base16 = {k, 4'd0};
      if (m24) begin
         return b[base24 +: 24];
      end
      return {8'd0, b[base16 +: 16]};
   endfunction

   // Burst split arithmetic: words left before the boundary decide one or two bursts.
   always_comb begin
      w_beats    = pixel_mode_24_i ? 3'd6 : 3'd4;
      w_room     = ROOM_W'(PAGE_WORDS) - ROOM_W'(r_addr[BOUNDARY_W-1:2]);
      w_fits     = (w_room >= ROOM_W'(w_beats));
      w_len1     = w_room[2:0] - 3'd1;
      w_len2     = w_beats - w_room[2:0] - 3'd1;
      w_page2    = {r_addr[31:BOUNDARY_W] + (32-BOUNDARY_W)'(1), {BOUNDARY_W{1'b0}}};
      w_beat_acc = r_valid_i & r_r_ready;
      w_pix_hs   = r_pix_valid & pix_ready_i;
      w_next_k   = r_pix_k + 3'd1;
   end

   // Main FSM: one group in flight, every handshake output registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_xoff      <= '0;
         r_yoff      <= '0;
         r_addr      <= '0;
         r_beats     <= '0;
         r_two       <= 1'b0;
         r_ar2_addr  <= '0;
         r_ar2_len   <= '0;
         r_beat_cnt  <= '0;
         r_pix_k     <= '0;
         r_req_ready <= 1'b1;
         r_ar_valid  <= 1'b0;
         r_ar_addr   <= '0;
         r_ar_len    <= '0;
         r_r_ready   <= 1'b0;
         r_pix_valid <= 1'b0;
         r_pix_data  <= '0;
         r_pix_last  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid_i) begin
                  r_x         <= req_x_i;
                  r_y         <= req_y_i;
                  r_req_ready <= 1'b0;
                  r_state     <= S_CALC0;
               end
            end
            S_CALC0: begin
               r_xoff  <= 18'({r_x, 1'b0}) + (pixel_mode_24_i ? 18'(r_x) : 18'd0);
               r_yoff  <= YOFF_W'(r_y) * YOFF_W'(pixel_stride_i);
               r_state <= S_CALC1;
            end
            S_CALC1: begin
               r_addr  <= src_addr_i + 32'(r_xoff) + 32'(r_yoff);
               r_state <= S_SPLIT;
            end
            S_SPLIT: begin
               r_beats    <= w_beats;
               r_beat_cnt <= '0;
               r_two      <= ~w_fits;
               r_ar2_addr <= w_page2;
               r_ar2_len  <= w_len2;
               r_ar_addr  <= r_addr;
               r_ar_len   <= w_fits ? (w_beats - 3'd1) : w_len1;
               r_ar_valid <= 1'b1;
               r_state    <= S_AR1;
            end
            S_AR1: begin
               if (ar_ready_i) begin
                  if (r_two) begin
                     r_ar_addr <= r_ar2_addr;
                     r_ar_len  <= r_ar2_len;
                     r_state   <= S_AR2;
                  end else begin
                     r_ar_valid <= 1'b0;
                     r_r_ready  <= 1'b1;
                     r_state    <= S_RDATA;
                  end
               end
            end
            S_AR2: begin
               if (ar_ready_i) begin
                  r_ar_valid <= 1'b0;
                  r_r_ready  <= 1'b1;
                  r_state    <= S_RDATA;
               end
            end
            S_RDATA: begin
               // Beat count alone ends the read; RLAST is not trusted for framing.
               if (w_beat_acc) begin
                  r_beat_cnt <= r_beat_cnt + 3'd1;
                  if (r_beat_cnt == r_beats - 3'd1) begin
                     r_r_ready   <= 1'b0;
                     r_pix_valid <= 1'b1;
                     r_pix_k     <= '0;
                     r_pix_last  <= 1'b0;
                     // Pixel 0 always lies in beat 0, which is already stored.
                     r_pix_data  <= f_pixel(r_buf, 3'd0, pixel_mode_24_i);
                     r_state     <= S_EMIT;
                  end
               end
            end
            S_EMIT: begin
               if (w_pix_hs) begin
                  if (r_pix_k == 3'd7) begin
                     r_pix_valid <= 1'b0;
                     r_pix_last  <= 1'b0;
                     r_pix_k     <= '0;
                     r_req_ready <= 1'b1;
                     r_state     <= S_IDLE;
                  end else begin
                     r_pix_k    <= w_next_k;
                     r_pix_data <= f_pixel(r_buf, w_next_k, pixel_mode_24_i);
                     r_pix_last <= (w_next_k == 3'd7);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Group buffer: beat n lands at bit 32n, counted across both bursts.
   always_ff @(posedge clk) begin
      if (r_state == S_RDATA && w_beat_acc) begin
         r_buf[{r_beat_cnt, 5'd0} +: 32] <= r_data_i;
      end
   end

`ifdef PIXEL_READ_RRESP_CHECK_EN
   // Sticky error flag: any accepted beat with a non-OKAY response.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_beat_acc && r_resp_i != 2'b00) begin
         r_err <= 1'b1;
      end
   end
   assign w_unused = r_last_i;
`else
   // Response checking disabled: the error flag stays low.
   always_ff @(posedge clk) begin
      r_err <= 1'b0;
   end
   assign w_unused = ^{r_last_i, r_resp_i};
`endif

   assign req_ready_o = r_req_ready;
   assign ar_valid_o  = r_ar_valid;
   assign ar_addr_o   = r_ar_addr;
   assign ar_len_o    = r_ar_len;
   assign r_ready_o   = r_r_ready;
   assign pix_valid_o = r_pix_valid;
   assign pix_data_o  = r_pix_data;
   assign pix_last_o  = r_pix_last;
   assign err_o       = r_err;

endmodule

// File: tb/tb_pixel_burst_reader.sv
// Directed bench for pixel_burst_reader: burst split, reassembly, backpressure, RRESP error, mid-read reset.
// Each group is driven by a scripted AXI slave; expected AR fields are hand-computed.
// Expected pixels come from the bench's own beat words.
module tb_pixel_burst_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        pixel_mode_24_i;
   logic [31:0] src_addr_i;
   logic [13:0] pixel_stride_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [15:0] req_x_i;
   logic [15:0] req_y_i;
   logic        ar_valid_o;
   logic        ar_ready_i;
   logic [31:0] ar_addr_o;
   logic [2:0]  ar_len_o;
   logic        r_valid_i;
   logic        r_ready_o;
   logic [31:0] r_data_i;
   logic [1:0]  r_resp_i;
   logic        r_last_i;
   logic        pix_valid_o;
   logic        pix_ready_i;
   logic [23:0] pix_data_o;
   logic        pix_last_o;
   logic        err_o;

   int checks   = 0;
   int failures = 0;
   string cur_test = "reset";

   // Group configuration and hand-computed expectations
   logic        g_m24;
   logic [31:0] g_src;
   logic [13:0] g_stride;
   logic [15:0] g_x, g_y;
   logic [31:0] e_a1, e_a2;
   logic [2:0]  e_l1, e_l2;
   logic        e_two;
   int          g_ar_stall;
   logic        g_pix_toggle;
   int          g_err_beat;
   logic [31:0] d [6];

   pixel_burst_reader #(.BOUNDARY_W(12), .STRIDE_W(14)) dut (
      .clk(clk), .rst(rst),
      .pixel_mode_24_i(pixel_mode_24_i), .src_addr_i(src_addr_i), .pixel_stride_i(pixel_stride_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_x_i(req_x_i), .req_y_i(req_y_i),
      .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o),
      .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
      .r_last_i(r_last_i),
      .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i), .pix_data_o(pix_data_o),
      .pix_last_o(pix_last_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s/%s observed=%0h expected=%0h", cur_test, tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_req_ready", 64'(req_ready_o), 64'd1);
      chk("rst_ar_valid",  64'(ar_valid_o),  64'd0);
      chk("rst_r_ready",   64'(r_ready_o),   64'd0);
      chk("rst_pix_valid", 64'(pix_valid_o), 64'd0);
      chk("rst_pix_last",  64'(pix_last_o),  64'd0);
      chk("rst_err",       64'(err_o),       64'd0);
   endtask

   // Runs one full group through the DUT with the configuration above.
   task automatic run_group();
      logic [191:0] b;
      logic [23:0]  expx;
      logic [23:0]  prev;
      logic         stalled;
      int           nb;
      int           n;
      nb = g_m24 ? 6 : 4;
      b  = '0;
      for (int i = 0; i < nb; i++) b[32*i +: 32] = d[i];

      pixel_mode_24_i = g_m24;
      src_addr_i      = g_src;
      pixel_stride_i  = g_stride;
      req_x_i         = g_x;
      req_y_i         = g_y;
      req_valid_i     = 1'b1;
      chk("req_ready_idle", 64'(req_ready_o), 64'd1);
      tick();
      req_valid_i = 1'b0;
      chk("req_ready_busy", 64'(req_ready_o), 64'd0);

      // Early R beat must not be accepted before the AR phase is over
      r_valid_i = 1'b1;
      r_data_i  = d[0];
      r_resp_i  = 2'b00;
      tick();
      tick();
      chk("ar_valid_early", 64'(ar_valid_o), 64'd0);
      tick();
      chk("ar1_valid", 64'(ar_valid_o), 64'd1);
      chk("ar1_addr",  64'(ar_addr_o),  64'(e_a1));
      chk("ar1_len",   64'(ar_len_o),   64'(e_l1));
      for (int i = 0; i < g_ar_stall; i++) begin
         tick();
         chk("ar1_hold_valid", 64'(ar_valid_o), 64'd1);
         chk("ar1_hold_addr",  64'(ar_addr_o),  64'(e_a1));
         chk("ar1_hold_len",   64'(ar_len_o),   64'(e_l1));
         chk("r_stall",        64'(r_ready_o),  64'd0);
      end
      ar_ready_i = 1'b1;
      tick();
      ar_ready_i = 1'b0;
      if (e_two) begin
         chk("ar2_valid", 64'(ar_valid_o), 64'd1);
         chk("ar2_addr",  64'(ar_addr_o),  64'(e_a2));
         chk("ar2_len",   64'(ar_len_o),   64'(e_l2));
         chk("r_stall2",  64'(r_ready_o),  64'd0);
         ar_ready_i = 1'b1;
         tick();
         ar_ready_i = 1'b0;
      end
      chk("ar_done", 64'(ar_valid_o), 64'd0);

      for (int i = 0; i < nb; i++) begin
         r_data_i  = d[i];
         r_resp_i  = (i == g_err_beat) ? 2'b10 : 2'b00;
         r_last_i  = e_two ? (i == int'(e_l1) || i == nb - 1) : (i == nb - 1);
         r_valid_i = 1'b1;
         chk("r_ready_beat", 64'(r_ready_o), 64'd1);
         tick();
      end
      r_valid_i = 1'b0;
      r_last_i  = 1'b0;
      r_resp_i  = 2'b00;
      chk("r_ready_done", 64'(r_ready_o),   64'd0);
      chk("pix_valid_on", 64'(pix_valid_o), 64'd1);

      n       = 0;
      stalled = 1'b0;
      prev    = '0;
      for (int c = 0; c < 64 && n < 8; c++) begin
         pix_ready_i = g_pix_toggle ? c[0] : 1'b1;
         if (stalled) chk("pix_hold", 64'(pix_data_o), 64'(prev));
         if (pix_valid_o) begin
            if (pix_ready_i) begin
               expx = g_m24 ? b[24*n +: 24] : {8'd0, b[16*n +: 16]};
               chk("pix_data", 64'(pix_data_o), 64'(expx));
               chk("pix_last", 64'(pix_last_o), 64'(n == 7));
               n++;
               stalled = 1'b0;
            end else begin
               prev    = pix_data_o;
               stalled = 1'b1;
            end
         end
         tick();
      end
      pix_ready_i = 1'b0;
      chk("pix_count",     64'(n),           64'd8);
      chk("pix_valid_off", 64'(pix_valid_o), 64'd0);
      chk("req_ready_back", 64'(req_ready_o), 64'd1);
   endtask

   initial begin
      rst = 1'b1;
      pixel_mode_24_i = 1'b0; src_addr_i = '0; pixel_stride_i = '0;
      req_valid_i = 1'b0; req_x_i = '0; req_y_i = '0;
      ar_ready_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0; r_resp_i = '0; r_last_i = 1'b0;
      pix_ready_i = 1'b0;
      g_ar_stall = 0; g_pix_toggle = 1'b0; g_err_beat = 99;
      tick();
      tick();
      chk_reset_outputs();
      rst = 1'b0;
      tick();

      // 1: 16bpp single burst at 0x1000_1010
      cur_test = "t1_16bpp";
      g_m24 = 1'b0; g_src = 32'h1000_0000; g_stride = 14'h0800; g_x = 16'd8; g_y = 16'd2;
      e_a1 = 32'h1000_1010; e_l1 = 3'd3; e_two = 1'b0; e_a2 = '0; e_l2 = '0;
      d[0] = 32'h2222_1111; d[1] = 32'h4444_3333; d[2] = 32'h6666_5555; d[3] = 32'h8888_7777;
      d[4] = '0; d[5] = '0;
      run_group();

      // 2: 24bpp split at the 4KB page: 4 beats at 0xFF0, 2 beats at 0x1000
      cur_test = "t2_24bpp_split";
      g_m24 = 1'b1; g_src = 32'h0000_0FF0; g_stride = 14'h0400; g_x = 16'd0; g_y = 16'd0;
      e_a1 = 32'h0000_0FF0; e_l1 = 3'd3; e_two = 1'b1; e_a2 = 32'h0000_1000; e_l2 = 3'd1;
      d[0] = 32'h44_332211; d[1] = 32'h88_776655; d[2] = 32'hCC_BBAA99;
      d[3] = 32'h10_FFEEDD; d[4] = 32'h14_131211; d[5] = 32'h18_171615;
      run_group();

      // 3: 16bpp one word before the page end: len 0 then len 2
      cur_test = "t3_16bpp_edge";
      g_m24 = 1'b0; g_src = 32'h2000_0FFC; g_stride = 14'h0100; g_x = 16'd0; g_y = 16'd0;
      e_a1 = 32'h2000_0FFC; e_l1 = 3'd0; e_two = 1'b1; e_a2 = 32'h2000_1000; e_l2 = 3'd2;
      d[0] = 32'hA1A1_B0B0; d[1] = 32'hA3A3_A2A2; d[2] = 32'hA5A5_A4A4; d[3] = 32'hA7A7_A6A6;
      run_group();

      // 4: backpressure, 24bpp x=16 y=3 stride 0x1E00 -> 0x8000+0x30+0x5A00
      cur_test = "t4_backpressure";
      g_m24 = 1'b1; g_src = 32'h0000_8000; g_stride = 14'h1E00; g_x = 16'd16; g_y = 16'd3;
      e_a1 = 32'h0000_DA30; e_l1 = 3'd5; e_two = 1'b0;
      g_ar_stall = 5; g_pix_toggle = 1'b1;
      d[0] = 32'h0302_0100; d[1] = 32'h0706_0504; d[2] = 32'h0B0A_0908;
      d[3] = 32'h0F0E_0D0C; d[4] = 32'h1312_1110; d[5] = 32'h1716_1514;
      run_group();
      g_ar_stall = 0; g_pix_toggle = 1'b0;

      // 5: SLVERR on beat 2; flag sticky across the following clean group
      cur_test = "t5_rresp";
      chk("err_before", 64'(err_o), 64'd0);
      g_m24 = 1'b0; g_src = 32'h0000_0100; g_stride = 14'h0040; g_x = 16'd8; g_y = 16'd1;
      e_a1 = 32'h0000_0150; e_l1 = 3'd3; e_two = 1'b0;
      d[0] = 32'hDEAD_BEEF; d[1] = 32'hCAFE_F00D; d[2] = 32'h1234_5678; d[3] = 32'h9ABC_DEF0;
      g_err_beat = 2;
      run_group();
      g_err_beat = 99;
`ifdef PIXEL_READ_RRESP_CHECK_EN
      chk("err_set", 64'(err_o), 64'd1);
      run_group();
      chk("err_sticky", 64'(err_o), 64'd1);
`else
      chk("err_off", 64'(err_o), 64'd0);
      run_group();
      chk("err_off_again", 64'(err_o), 64'd0);
`endif

      // 6: reset during RDATA, then a clean group
      cur_test = "t6_reset_mid";
      pixel_mode_24_i = 1'b0; src_addr_i = 32'h1000_0000; pixel_stride_i = 14'h0800;
      req_x_i = 16'd8; req_y_i = 16'd2; req_valid_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      tick(); tick(); tick();
      chk("t6_ar_valid", 64'(ar_valid_o), 64'd1);
      ar_ready_i = 1'b1;
      tick();
      ar_ready_i = 1'b0;
      chk("t6_in_rdata", 64'(r_ready_o), 64'd1);
      r_valid_i = 1'b1; r_data_i = 32'h5555_AAAA; r_resp_i = 2'b10;
      tick(); tick();
      r_valid_i = 1'b0; r_resp_i = 2'b00;
      rst = 1'b1;
      tick();
      chk_reset_outputs();
      rst = 1'b0;
      tick();
      g_m24 = 1'b0; g_src = 32'h1000_0000; g_stride = 14'h0800; g_x = 16'd8; g_y = 16'd2;
      e_a1 = 32'h1000_1010; e_l1 = 3'd3; e_two = 1'b0;
      d[0] = 32'h0BAD_F00D; d[1] = 32'h1357_2468; d[2] = 32'hFEDC_BA98; d[3] = 32'h0F0F_F0F0;
      run_group();
      chk("t6_err_clear", 64'(err_o), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
